// File: rtl/pll_rst_ctrl.sv
// pll_rst_ctrl: PLL start-up and supervision sequencer on the 24 MHz reference clock.
// It pulses the PLL reset, filters the synchronized extlock, holds the system reset
// for a settling time, then releases it. Lock loss or a lock timeout re-initialises the PLL.
module pll_rst_ctrl #(
   parameter int POR_CYCLES   = 16,
   parameter int LOCK_FILTER  = 64,
   parameter int HOLD_CYCLES  = 256,
   parameter int LOCK_TIMEOUT = 24000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       extlock,
   input  logic       soft_rst_req,
   output logic       pll_rst,
   output logic       sys_resetn,
   output logic       locked,
   output logic       lock_lost,
   output logic [3:0] retry_cnt
);

   localparam int MAX_AB  = (POR_CYCLES > LOCK_FILTER) ? POR_CYCLES : LOCK_FILTER;
   localparam int MAX_CD  = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CW-1:0] POR_LAST     = CW'(POR_CYCLES - 1);
   localparam logic [CW-1:0] FILTER_LAST  = CW'(LOCK_FILTER - 1);
   localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);

   localparam logic [2:0] S_PLL_RST   = 3'd0;
   localparam logic [2:0] S_WAIT_LOCK = 3'd1;
   localparam logic [2:0] S_FILTER    = 3'd2;
   localparam logic [2:0] S_HOLD      = 3'd3;
   localparam logic [2:0] S_RUN       = 3'd4;

   logic [1:0]    sync_q;
   logic          extlock_s;
   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          cnt_clr;
   logic          loss_evt;
   logic          timeout_evt;

   assign extlock_s = sync_q[1];

   // Two-flop synchronizer bringing the asynchronous PLL lock into the clk domain.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], extlock};
      end
   end

   // Next-state logic: soft request beats lock loss, which beats counter expiry.
   always_comb begin
      state_d     = state_q;
      cnt_clr     = 1'b0;
      loss_evt    = 1'b0;
      timeout_evt = 1'b0;
      if (soft_rst_req) begin
         state_d = S_PLL_RST;
         cnt_clr = 1'b1;
      end else begin
         case (state_q)
            S_PLL_RST: begin
               if (cnt_q == POR_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
               if (extlock_s) begin
                  state_d = S_FILTER;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  state_d     = S_PLL_RST;
                  timeout_evt = 1'b1;
               end
            end
            S_FILTER: begin
               if (!extlock_s) state_d = S_WAIT_LOCK;
               else if (cnt_q == FILTER_LAST) state_d = S_HOLD;
            end
            S_HOLD: begin
               if (!extlock_s) begin
                  state_d  = S_PLL_RST;
                  loss_evt = 1'b1;
               end else if (cnt_q == HOLD_LAST) begin
                  state_d = S_RUN;
               end
            end
            S_RUN: begin
               if (!extlock_s) begin
                  state_d  = S_PLL_RST;
                  loss_evt = 1'b1;
               end
            end
            default: state_d = S_PLL_RST;
         endcase
      end
      if (state_d != state_q) cnt_clr = 1'b1;
   end

   // Shared cycle counter: cleared on any state change or soft request, idle in RUN.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) cnt_d = '0;
      else if (state_q != S_RUN) cnt_d = cnt_q + CW'(1);
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_PLL_RST;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Registered outputs decoded from next state so they switch with the state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pll_rst    <= 1'b1;
         sys_resetn <= 1'b0;
         locked     <= 1'b0;
         lock_lost  <= 1'b0;
         retry_cnt  <= '0;
      end else begin
         pll_rst    <= (state_d == S_PLL_RST);
         sys_resetn <= (state_d == S_RUN);
         locked     <= (state_d == S_RUN);
         lock_lost  <= loss_evt;
         if (timeout_evt && (retry_cnt != 4'hF)) retry_cnt <= retry_cnt + 4'd1;
      end
   end

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// tb_pll_rst_ctrl: directed bench for pll_rst_ctrl with POR=4, FILTER=8, HOLD=16, TIMEOUT=10.
// Observed vector is {pll_rst, sys_resetn, locked, lock_lost, retry_cnt[3:0]}.
module tb_pll_rst_ctrl;

   logic       clk = 1'b0;
   logic       resetn = 1'b1;
   logic       extlock = 1'b0;
   logic       soft_rst_req = 1'b0;
   logic       pll_rst;
   logic       sys_resetn;
   logic       locked;
   logic       lock_lost;
   logic [3:0] retry_cnt;

   int checks = 0;
   int errors = 0;

   pll_rst_ctrl #(
      .POR_CYCLES  (4),
      .LOCK_FILTER (8),
      .HOLD_CYCLES (16),
      .LOCK_TIMEOUT(10)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .extlock     (extlock),
      .soft_rst_req(soft_rst_req),
      .pll_rst     (pll_rst),
      .sys_resetn  (sys_resetn),
      .locked      (locked),
      .lock_lost   (lock_lost),
      .retry_cnt   (retry_cnt)
   );

   // 10-unit reference clock; rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Guard against a stuck run.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance one rising edge and settle just after it.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Assert reset for two edges, release it mid-cycle; next posedge is edge 1.
   task automatic do_reset(input logic ext);
      resetn       = 1'b0;
      extlock      = ext;
      soft_rst_req = 1'b0;
      repeat (2) tick();
      #2 resetn = 1'b1;
   endtask

   task automatic test_reset;
      logic [7:0] got;
      #2 resetn = 1'b0;
      #2;
      got = {pll_rst, sys_resetn, locked, lock_lost, retry_cnt};
      checks++;
      if (got !== 8'b1000_0000) begin
         errors++;
         $display("FAIL reset_async: got %b want %b", got, 8'b1000_0000);
      end
      repeat (3) tick();
      got = {pll_rst, sys_resetn, locked, lock_lost, retry_cnt};
      checks++;
      if (got !== 8'b1000_0000) begin
         errors++;
         $display("FAIL reset_held: got %b want %b", got, 8'b1000_0000);
      end
   endtask

   task automatic test_startup;
      logic [7:0] got, exp;
      do_reset(1'b1);
      for (int k = 1; k <= 32; k++) begin
         tick();
         exp = {k < 4, k >= 29, k >= 29, 1'b0, 4'd0};
         got = {pll_rst, sys_resetn, locked, lock_lost, retry_cnt};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL startup edge %0d: got %b want %b", k, got, exp);
         end
      end
   endtask

   task automatic test_glitch;
      logic [7:0] got, exp;
      do_reset(1'b0);
      for (int k = 1; k <= 40; k++) begin
         tick();
         exp = {k < 4, k >= 37, k >= 37, 1'b0, 4'd0};
         got = {pll_rst, sys_resetn, locked, lock_lost, retry_cnt};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL glitch edge %0d: got %b want %b", k, got, exp);
         end
         if (k == 4) extlock = 1'b1;
         if (k == 9) extlock = 1'b0;
         if (k == 10) extlock = 1'b1;
      end
   endtask

   task automatic test_timeout;
      logic [7:0] got, exp;
      logic [3:0] r;
      do_reset(1'b0);
      for (int k = 1; k <= 290; k++) begin
         tick();
         r   = (k / 14 > 15) ? 4'd15 : 4'(k / 14);
         exp = {(k % 14) < 4, 1'b0, 1'b0, 1'b0, r};
         got = {pll_rst, sys_resetn, locked, lock_lost, retry_cnt};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL timeout edge %0d: got %b want %b", k, got, exp);
         end
      end
   endtask

   task automatic test_lock_loss;
      logic [7:0] got, exp;
      do_reset(1'b1);
      repeat (32) tick();
      extlock = 1'b0;
      for (int m = 1; m <= 2; m++) begin
         tick();
         got = {pll_rst, sys_resetn, locked, lock_lost, retry_cnt};
         checks++;
         if (got !== 8'b0110_0000) begin
            errors++;
            $display("FAIL loss_sync edge %0d: got %b want %b", m, got, 8'b0110_0000);
         end
      end
      tick();
      for (int m = 0; m <= 31; m++) begin
         if (m > 0) tick();
         exp = {m < 4, m >= 29, m >= 29, m == 0, 4'd0};
         got = {pll_rst, sys_resetn, locked, lock_lost, retry_cnt};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL loss_reseq +%0d: got %b want %b", m, got, exp);
         end
         if (m == 0) extlock = 1'b1;
      end
   endtask

   task automatic test_soft;
      logic [7:0] got, exp;
      do_reset(1'b0);
      for (int k = 1; k <= 30; k++) begin
         tick();
         exp = {(k < 4) || (k >= 14 && k < 18), 1'b0, 1'b0, 1'b0, 4'(k >= 14)};
         got = {pll_rst, sys_resetn, locked, lock_lost, retry_cnt};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL soft_pre edge %0d: got %b want %b", k, got, exp);
         end
         if (k == 14) extlock = 1'b1;
      end
      soft_rst_req = 1'b1;
      for (int m = 0; m <= 31; m++) begin
         tick();
         if (m == 0) soft_rst_req = 1'b0;
         exp = {m < 4, m >= 29, m >= 29, 1'b0, 4'd1};
         got = {pll_rst, sys_resetn, locked, lock_lost, retry_cnt};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL soft_hold +%0d: got %b want %b", m, got, exp);
         end
      end
      extlock = 1'b0;
      for (int m = 1; m <= 2; m++) begin
         tick();
         got = {pll_rst, sys_resetn, locked, lock_lost, retry_cnt};
         checks++;
         if (got !== 8'b0110_0001) begin
            errors++;
            $display("FAIL soft_run_pre edge %0d: got %b want %b", m, got, 8'b0110_0001);
         end
      end
      soft_rst_req = 1'b1;
      for (int m = 0; m <= 1; m++) begin
         tick();
         soft_rst_req = 1'b0;
         got = {pll_rst, sys_resetn, locked, lock_lost, retry_cnt};
         checks++;
         if (got !== 8'b1000_0001) begin
            errors++;
            $display("FAIL soft_vs_loss +%0d: got %b want %b", m, got, 8'b1000_0001);
         end
      end
   endtask

   task automatic test_async_reset;
      logic [7:0] got, exp;
      do_reset(1'b0);
      for (int k = 1; k <= 30; k++) begin
         tick();
         exp = {(k < 4) || (k >= 14 && k < 18), 1'b0, 1'b0, 1'b0, 4'(k >= 14)};
         got = {pll_rst, sys_resetn, locked, lock_lost, retry_cnt};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL arst_pre edge %0d: got %b want %b", k, got, exp);
         end
         if (k == 14) extlock = 1'b1;
      end
      #2 resetn = 1'b0;
      #1;
      got = {pll_rst, sys_resetn, locked, lock_lost, retry_cnt};
      checks++;
      if (got !== 8'b1000_0000) begin
         errors++;
         $display("FAIL arst_hold: got %b want %b", got, 8'b1000_0000);
      end
      #2 resetn = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         tick();
         exp = {k < 4, k >= 29, k >= 29, 1'b0, 4'd0};
         got = {pll_rst, sys_resetn, locked, lock_lost, retry_cnt};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL arst_restart edge %0d: got %b want %b", k, got, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_glitch();
      test_timeout();
      test_lock_loss();
      test_soft();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pll_rst_ctrl.md
Name: pll_rst_ctrl

Overview:
- Sequencer that sits directly downstream of the board PLL; runs on the 24 MHz reference clock.
- Drives the PLL reset input and consumes its extlock output.
- Filters lock, then releases the system reset request for the picorv32 core.
- Detects lock loss or timeout and re-initialises the PLL automatically.

Parameters:
POR_CYCLES, 16, cycles pll_rst is held high per PLL reset pulse (>=1)
LOCK_FILTER, 64, consecutive synchronized-lock cycles required before lock is accepted (>=1)
HOLD_CYCLES, 256, cycles sys_resetn stays low after lock is accepted (>=1)
LOCK_TIMEOUT, 24000, cycles in WAIT_LOCK without lock before the PLL reset is retried (1 ms at 24 MHz) (>=1)

Ports:
clk  in  1  reference clock (24 MHz board clock, free-running)
resetn  in  1  asynchronous active-low reset
extlock  in  1  PLL lock, asynchronous to clk
soft_rst_req  in  1  synchronous one-cycle request to re-initialise the PLL
pll_rst  out  1  active-high reset to the PLL
sys_resetn  out  1  active-low system reset request (core domain resynchronises it)
locked  out  1  high only in RUN
lock_lost  out  1  one-cycle pulse on lock loss in HOLD or RUN
retry_cnt  out  4  saturating count of timeout retries

Behaviour:
- Reset/sync decision: one clock (clk); resetn asynchronous assert, active-low; all flops clear on resetn low.
- Reset values: state=PLL_RST, counter=0, pll_rst=1, sys_resetn=0, locked=0, lock_lost=0, retry_cnt=0, sync flops=0.
- Lock synchronizer: extlock passes through a 2-flop synchronizer to give extlock_s; only extlock_s is used.
- Counter: one shared counter, width clog2 of the max parameter; cleared on every state change.
- Outputs: all registered, decoded from next-state, so they change on the same edge as the state.
- Priority each cycle: soft_rst_req > lock loss > counter expiry.

State PLL_RST:
- pll_rst=1, sys_resetn=0.
- Counter reaches POR_CYCLES-1 -> WAIT_LOCK.
- soft_rst_req here restarts the count.

State WAIT_LOCK:
- pll_rst=0.
- extlock_s=1 -> FILTER.
- Counter reaches LOCK_TIMEOUT-1 -> PLL_RST, retry_cnt+1 (saturates at 15).
- If extlock_s=1 and timeout coincide, lock wins.

State FILTER:
- extlock_s=0 -> WAIT_LOCK; timeout timer restarts from 0.
- Counter reaches LOCK_FILTER-1 with extlock_s=1 -> HOLD.

State HOLD:
- sys_resetn=0.
- extlock_s=0 -> PLL_RST with lock_lost pulse.
- Counter reaches HOLD_CYCLES-1 -> RUN.

State RUN:
- sys_resetn=1, locked=1.
- extlock_s=0 -> PLL_RST with lock_lost pulse; sys_resetn and locked fall on that edge.

Any state:
- soft_rst_req=1 -> PLL_RST.
- No lock_lost pulse on soft request.
- retry_cnt unchanged by soft request.

Timing and clearing:
- Release latency with extlock_s already high at WAIT_LOCK entry: sys_resetn rises on edge POR_CYCLES+1+LOCK_FILTER+HOLD_CYCLES after resetn deassertion (edge 1 = first rising edge).
- Lock-loss latency: extlock low to sys_resetn low is 3 edges (2 sync + 1 register).
- retry_cnt is cleared only by resetn.
- resetn asserted mid-operation: all outputs return to reset values immediately (asynchronously).

Test Plan:
1. Start-up, extlock tied high (POR=4, FILTER=8, HOLD=16) -> pll_rst falls on edge 4; sys_resetn and locked rise on edge 29; retry_cnt=0.
2. Glitchy lock: extlock high 5 cycles, low 1, then steady -> FILTER aborts to WAIT_LOCK; sys_resetn rises only after 8 uninterrupted extlock_s cycles plus 16 HOLD cycles; no pll_rst pulse.
3. No lock (LOCK_TIMEOUT=10), extlock held low for 20 retries -> pll_rst re-pulses every 14 cycles; retry_cnt stops at 15; sys_resetn stays 0.
4. Lock loss in RUN: extlock drops -> lock_lost 1-cycle pulse and sys_resetn=0 three edges later; pll_rst=1 for 4 cycles; full re-sequence follows.
5. soft_rst_req in HOLD, and simultaneously with extlock drop in RUN -> PLL_RST entered, lock_lost=0 in both cases, retry_cnt unchanged.
6. resetn pulsed low mid-HOLD -> pll_rst=1, sys_resetn=0, retry_cnt=0 asynchronously; sequence restarts from edge 1.
